// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction layout,
// PC increment and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_INC     = 4;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 21;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic {
        FETCH_S = 1'b0,
        WAIT_S  = 1'b1
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM and
// a one-entry output buffer toward decode, with redirect flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [ADDR_W-1:0]   out_pc,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc
);

    fetch_state_e         state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 drop_q, drop_d;
    logic                 out_valid_q, out_valid_d;
    logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]    out_pc_q, out_pc_d;
    logic [ADDR_W-1:0]    redirect_target;
    logic                 buf_free;

    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    // The buffer is guaranteed empty when the response lands because a request
    // only goes out while the buffer is empty or draining.
    assign buf_free        = ~out_valid_q | out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH_S;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        imem_req    = 1'b0;

        case (state_q)
            FETCH_S: begin
                imem_req = buf_free & ~redirect_valid & ~reset;
                if (imem_req && imem_gnt) begin
                    state_d = WAIT_S;
                    drop_d  = 1'b0;
                end
            end
            WAIT_S: begin
                if (imem_rvalid) begin
                    state_d = FETCH_S;
                    drop_d  = 1'b0;
                    if (!drop_q && !redirect_valid) begin
                        out_valid_d = 1'b1;
                        out_instr_d = imem_rdata;
                        out_pc_d    = pc_q;
                        pc_d        = pc_q + ADDR_W'(PC_INC);
                    end
                end else if (redirect_valid) begin
                    // Response still owed by memory; swallow it when it returns.
                    drop_d = 1'b1;
                end
            end
        endcase

        if (redirect_valid) begin
            pc_d        = redirect_target;
            out_valid_d = 1'b0;
        end
    end

    assign imem_addr  = pc_q;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_pc     = out_pc_q;
    assign out_opcode = opcode_of(out_instr_q);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the main decoder (`control`). It holds the PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake. It buffers the returned word in a one-entry output register with a valid/ready handshake and exposes instr[31:21] as the 11-bit opcode consumed by decode. Taken branches (B/CBZ, resolved downstream from branch/uncond_branch) come back as a redirect that flushes the stage and drops any response still in flight.

Parameters:
ADDR_W, 64, PC and memory address width
RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address (equals pc while imem_req=1)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid (at least 1 cycle after gnt)
imem_rdata  in  32  instruction word
out_valid  out  1  buffered instruction valid to decode
out_ready  in  1  decode accepts the instruction this cycle
out_instr  out  32  buffered instruction
out_opcode  out  11  out_instr[31:21]; feeds control.opcode
out_pc  out  ADDR_W  address of out_instr
redirect_valid  in  1  taken branch or jump; flush and refetch
redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored and forced to 0

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, state=FETCH, drop=0, out_valid=0.
  - out_instr=0, out_pc=0, imem_req=0 during reset.
- States: FETCH, WAIT. At most one request is outstanding.
- FETCH:
  - imem_req = (~out_valid | out_ready) & ~redirect_valid.
  - imem_addr = pc.
  - On imem_req & imem_gnt: go to WAIT, drop=0.
  - req held with a stable address until gnt.
- WAIT:
  - imem_req=0.
  - On imem_rvalid & ~drop & ~redirect_valid: out_instr=imem_rdata, out_pc=pc, out_valid=1, pc=pc+4 (wraps mod 2^ADDR_W), go to FETCH.
  - On imem_rvalid & drop: discard the data, drop=0, go to FETCH. pc already holds the redirect target.
- Buffer guarantee: a request is issued only when the buffer is empty or draining that cycle, so the buffer is always empty when the response arrives. No overflow path exists.
- Output handshake: transfer when out_valid & out_ready. Without a new fill, out_valid drops to 0 the next cycle.
  - out_instr, out_pc and out_opcode stay stable while out_valid & ~out_ready.
- Redirect (priority over everything except reset):
  - pc=redirect_pc & ~3; out_valid=0 next cycle.
  - A handshake completing in the same cycle still counts as transferred.
  - In WAIT without rvalid: drop=1, stay in WAIT.
  - In WAIT with rvalid that same cycle: discard the data, go to FETCH.
  - In FETCH: no request is issued that cycle; fetch from the new pc next cycle.
  - Back-to-back redirects: the last one wins. drop stays 1 until the one outstanding response returns.
- imem_rvalid in FETCH: spurious, ignored.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency and gnt in the same cycle as req.
- Reset mid-transaction returns to FETCH immediately. An in-flight response after reset is ignored because the stage is in FETCH.
- out_opcode is combinational from out_instr. The downstream decoder's default (unknown opcode) case handles out_instr=0.

Decomposition:
- Shared header cpu_defs.vh (already included by decode) gains:
  - INSTR_W=32
  - fetch state encodings FETCH_S=1'b0, WAIT_S=1'b1
  - PC_INC=4
  - OPCODE_MSB=31, OPCODE_LSB=21
- No sub-module. The PC register, FSM and output buffer stay in one module of about 150–200 lines.

Test Plan:
1. Reset release, memory returns 0x8B020020 (ADD reg) 1 cycle after gnt -> imem_addr=0, then out_valid=1, out_instr=0x8B020020, out_opcode=11'h458, out_pc=0. The next request has addr=4.
2. out_ready=0 for 5 cycles after the first fill -> out_* stable, imem_req=0 throughout. out_ready=1 -> handshake, then the request to addr 4 is issued in that same cycle.
3. redirect_valid=1, redirect_pc=0x103 while in WAIT; response 0xDEADBEEF arrives 3 cycles later -> word dropped, out_valid stays 0. The next imem_addr=0x100.
4. redirect_valid together with imem_rvalid in the same cycle, redirect_pc=0x40 -> data discarded, out_valid=0. The next request addr=0x40, and pc does not become old pc+4.
5. imem_gnt withheld for 4 cycles -> imem_req=1 with imem_addr constant. Wrap case: RESET_PC=0xFFFF_FFFF_FFFF_FFFC -> after one fetch, the next addr=0.
6. Assert reset asynchronously mid-WAIT (between clock edges) -> imem_req=0 and out_valid=0 immediately. A stale rvalid after release is ignored, and the first request goes to RESET_PC.
